dmem_arbiter: RTL



---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_burst_agen.sv | 53 +++++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: default widths, beat stride, FSM state codes.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int BEAT_STRIDE = 2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t BURST = 2'd1;
  localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/dmem_burst_agen.sv
// Burst address generator: latches base and clamped length on load, steps one beat per advance.
// Address and last-beat flag are combinational from the registered beat index; no backpressure.
module dmem_burst_agen
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BURST_MAX = 16,
  parameter int LEN_W     = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] beat_addr,
  output logic              last_beat
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_idx_q, beat_idx_d;

  always_comb begin
    base_d     = base_q;
    len_d      = len_q;
    beat_idx_d = beat_idx_q;
    if (load) begin
      base_d     = base;
      len_d      = (len > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : len;
      beat_idx_d = '0;
    end else if (advance) begin
      beat_idx_d = beat_idx_q + 1'b1;
    end
  end

  // Sum is truncated to ADDR_W so bursts wrap through address 0.
  assign beat_addr = base_q + ADDR_W'(beat_idx_q) * ADDR_W'(BEAT_STRIDE);
  assign last_beat = (beat_idx_q == len_q - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q     <= '0;
      len_q      <= '0;
      beat_idx_q <= '0;
    end else begin
      base_q     <= base_d;
      len_q      <= len_d;
      beat_idx_q <= beat_idx_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU MEM stage (fixed priority, zero latency) and a burst DMA.
// DMA reads return one cycle after grant; a starved beat is forced after MAX_WAIT lost cycles, stalling the CPU.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = 16,
  parameter int MAX_WAIT  = 8,
  localparam int LEN_W    = $clog2(BURST_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_start,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_base,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic              dma_wvalid,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_wready,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_byte,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              burst_we_q, burst_we_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic              load, dma_pending, wait_full, dma_grant, last_beat;
  logic [ADDR_W-1:0] beat_addr;

  dmem_burst_agen #(
    .ADDR_W    (ADDR_W),
    .BURST_MAX (BURST_MAX),
    .LEN_W     (LEN_W)
  ) u_agen (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .advance   (dma_grant),
    .base      (dma_base),
    .len       (dma_len),
    .beat_addr (beat_addr),
    .last_beat (last_beat)
  );

  assign load        = (state_q == IDLE) && dma_start && (dma_len != '0);
  assign dma_pending = (state_q == BURST) && (!burst_we_q || dma_wvalid);
  assign wait_full   = (wait_cnt_q == WAIT_W'(MAX_WAIT));
  assign dma_grant   = dma_pending && (!cpu_req || wait_full);

  always_comb begin
    state_d    = state_q;
    burst_we_d = burst_we_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d    = BURST;
          burst_we_d = dma_we;
        end
      end
      BURST:   if (dma_grant && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-data gaps leave the counter untouched: only a real, denied beat counts as lost.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (dma_grant || state_q != BURST) begin
      wait_cnt_d = '0;
    end else if (dma_pending && !wait_full) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_comb begin
    dma_rvalid_d = dma_grant && !burst_we_q;
    dma_rdata_d  = dma_rvalid_d ? mem_rdata : dma_rdata_q;
  end

  always_comb begin
    if (dma_grant) begin
      mem_addr  = beat_addr;
      mem_wdata = dma_wdata;
      mem_we    = burst_we_q;
      mem_byte  = 1'b0;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_req && cpu_we;
      mem_byte  = cpu_req && cpu_byte;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = cpu_req && dma_grant;
  assign dma_wready = dma_grant && burst_we_q;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;
  assign dma_busy   = (state_q == BURST) || (state_q == DONE);
  assign dma_done   = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      burst_we_q   <= 1'b0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      burst_we_q   <= burst_we_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

endmodule
